dsc_operand_loader: RTL

Front-end sequencer for `dsc_serial_mul`.
- Accepts `NUM_INPUTS` binary operands, one per handshake, on a valid/ready stream.
- Packs them into the multiplier's operand array, drives `en` for one operation and waits for `done`.
- Captures the `NUM_INPUTS*DATA_WIDTH`-bit product and returns it on a valid/ready result stream.
- Sits directly upstream of the multiplier and owns its enable; includes a watchdog against a missing `done`.

---
 rtl/dsc_pkg.sv | 19 +
 rtl/dsc_timeout_counter.sv | 32 +++
 rtl/dsc_operand_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dsc_pkg.sv
// Shared definitions for the dsc serial multiplier slice: loader state encoding,
// default operand geometry and the default watchdog limit.
package dsc_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } dsc_ld_state_t;

  localparam int DSC_DATA_WIDTH = 5;
  localparam int DSC_NUM_INPUTS = 2;

  // The multiplier needs up to 2^(total bits) cycles; the extra 4 cover its pipeline slack.
  function automatic int dsc_timeout(input int data_width, input int num_inputs);
    return int'((32'd1 << (data_width * num_inputs)) + 32'd4);
  endfunction

endpackage

// File: rtl/dsc_timeout_counter.sv
// Watchdog counter for the operand loader: counts enabled cycles starting at 1
// and flags the cycle on which the count reaches TIMEOUT.
module dsc_timeout_counter #(
  parameter int TIMEOUT = 1028
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;

  // Cycle count; the clear value is 1 so the first enabled cycle reads as cycle 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CW'(1);
    end else if (clr) begin
      cnt_r <= CW'(1);
    end else if (en && (cnt_r != CW'(TIMEOUT))) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = en && (cnt_r == CW'(TIMEOUT));

endmodule

// File: rtl/dsc_operand_loader.sv
// Front-end sequencer for dsc_serial_mul: collects operands, runs one multiply
// under a watchdog and hands the product to a valid/ready consumer.
module dsc_operand_loader
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = DSC_DATA_WIDTH,
  parameter int NUM_INPUTS = DSC_NUM_INPUTS,
  parameter int TIMEOUT    = dsc_timeout(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [DATA_WIDTH-1:0]            op_data,
  output logic                             mul_en,
  output logic [DATA_WIDTH-1:0]            mul_data [NUM_INPUTS],
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_result,
  input  logic                             mul_done,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] res_data,
  output logic                             err,
  output logic                             busy
);

  localparam int RW    = NUM_INPUTS * DATA_WIDTH;
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  dsc_ld_state_t         state_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  op_ready_r;
  logic                  mul_en_r;
  logic [DATA_WIDTH-1:0] mul_data_r [NUM_INPUTS];
  logic                  res_valid_r;
  logic [RW-1:0]         res_data_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  wd_clr_s;
  logic                  wd_en_s;
  logic                  wd_tc_s;

  // op_ready_r is registered, so an accept always matches what upstream saw.
  assign accept_s = op_valid && op_ready_r;
  assign wd_en_s  = (state_r == RUN);
  assign wd_clr_s = (state_r != RUN);

  dsc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr_s),
    .en  (wd_en_s),
    .tc  (wd_tc_s)
  );

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= LOAD;
      idx_r       <= '0;
      op_ready_r  <= 1'b0;
      mul_en_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        mul_data_r[i] <= '0;
      end
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            mul_data_r[idx_r] <= op_data;
            if (idx_r == '0) begin
              err_r <= 1'b0;
            end else begin
              err_r <= err_r;
            end
            if (idx_r == IDX_W'(NUM_INPUTS - 1)) begin
              idx_r      <= '0;
              op_ready_r <= 1'b0;
              mul_en_r   <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= RUN;
            end else begin
              idx_r      <= idx_r + IDX_W'(1);
              op_ready_r <= 1'b1;
            end
          end else begin
            op_ready_r <= 1'b1;
          end
        end
        RUN: begin
          // A done on the watchdog's final cycle still counts as a good result.
          if (mul_done) begin
            res_data_r  <= mul_result;
            res_valid_r <= 1'b1;
            mul_en_r    <= 1'b0;
            state_r     <= RESULT;
          end else if (wd_tc_s) begin
            err_r      <= 1'b1;
            mul_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            op_ready_r <= 1'b1;
            state_r    <= LOAD;
          end else begin
            state_r <= RUN;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            op_ready_r  <= 1'b1;
            state_r     <= LOAD;
          end else begin
            state_r <= RESULT;
          end
        end
        default: begin
          state_r     <= LOAD;
          idx_r       <= '0;
          op_ready_r  <= 1'b0;
          mul_en_r    <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = op_ready_r;
  assign mul_en    = mul_en_r;
  assign mul_data  = mul_data_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign err       = err_r;
  assign busy      = busy_r;

endmodule
